// File: rtl/edge_detect_mc.sv
// Purpose: multi-channel synchronised, glitch-filtered edge detector with sticky event flags.
// Latency: level/pulse update SYNC_STAGES+filt_len edges after the input is captured.
// Backpressure: none; free-running, one event pulse per qualified level transition.
// Optional feature: define EDGE_CNT_EN to add saturating per-channel event counters (evt_cnt port).
module edge_detect_mc #(
  parameter int CH          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       sig_in,
  input  logic [2*CH-1:0]     mode,
  input  logic [FILT_W-1:0]   filt_len,
  input  logic [CH-1:0]       evt_clr,
  output logic [CH-1:0]       level,
  output logic [CH-1:0]       pulse,
  output logic [CH-1:0]       evt_flag,
  output logic                any_evt
`ifdef EDGE_CNT_EN
  ,
  output logic [CH*CNT_W-1:0] evt_cnt
`endif
);

  localparam logic [FILT_W-1:0] FILT_ONE = {{(FILT_W-1){1'b0}}, 1'b1};

  // Elaboration-time sanity check on the configuration.
  if (CH < 1 || CH > 32 || SYNC_STAGES < 2 || FILT_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("edge_detect_mc: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] sync_q [CH];
  logic [FILT_W-1:0]      fcnt   [CH];
  logic [CH-1:0]          s;
  logic [CH-1:0]          upd;
  logic [CH-1:0]          hit;

  // Per-channel view of the synchroniser output, update strobe and mode qualification.
  always_comb begin
    s   = '0;
    upd = '0;
    hit = '0;
    for (int i = 0; i < CH; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
      // >= rather than == so that shrinking filt_len mid-count still lets the level move.
      upd[i] = (s[i] != level[i]) && (fcnt[i] >= filt_len);
      case (mode[2*i +: 2])
        2'b00:   hit[i] = s[i] & ~level[i];
        2'b01:   hit[i] = ~s[i] & level[i];
        2'b10:   hit[i] = s[i] ^ level[i];
        default: hit[i] = 1'b0;
      endcase
    end
  end

  // Synchroniser chains: stage 0 samples the raw input, last stage feeds the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sig_in[i]};
      end
    end
  end

  // Glitch filter: level follows s only after filt_len+1 consecutive cycles of difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      pulse <= '0;
      for (int i = 0; i < CH; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        pulse[i] <= upd[i] & hit[i];
        if (s[i] == level[i]) begin
          fcnt[i] <= '0;
        end else if (upd[i]) begin
          level[i] <= s[i];
          fcnt[i]  <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FILT_ONE;
        end
      end
    end
  end

  // Sticky flags: a pulse sets the flag and beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_flag <= '0;
    end else begin
      evt_flag <= pulse | (evt_flag & ~evt_clr);
    end
  end

  assign any_evt = |evt_flag;

`ifdef EDGE_CNT_EN
  logic [CNT_W-1:0] ecnt [CH];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating event counters; a clear coinciding with a pulse leaves a count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) ecnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (evt_clr[i]) begin
          ecnt[i] <= pulse[i] ? CNT_ONE : '0;
        end else if (pulse[i] && (ecnt[i] != {CNT_W{1'b1}})) begin
          ecnt[i] <= ecnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Flatten the counter array onto the output bus.
  always_comb begin
    evt_cnt = '0;
    for (int i = 0; i < CH; i++) evt_cnt[i*CNT_W +: CNT_W] = ecnt[i];
  end
`endif

endmodule

// File: tb/tb_edge_detect_mc.sv
// Directed bench for edge_detect_mc: pulse expectations are scheduled into a queue at the
// moment the input is driven and checked every cycle; level/flag/counter checks are inline.
// Build with or without EDGE_CNT_EN; the counter section only runs when it is defined.
module tb_edge_detect_mc;

  localparam int CH    = 8;
  localparam int CNT_W = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] sig_in;
  logic [2*CH-1:0] mode;
  logic [3:0]    filt_len;
  logic [CH-1:0] evt_clr;
  logic [CH-1:0] level;
  logic [CH-1:0] pulse;
  logic [CH-1:0] evt_flag;
  logic          any_evt;
`ifdef EDGE_CNT_EN
  logic [CH*CNT_W-1:0] evt_cnt;
`endif

  edge_detect_mc #(.CH(CH), .SYNC_STAGES(2), .FILT_W(4), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .mode     (mode),
    .filt_len (filt_len),
    .evt_clr  (evt_clr),
    .level    (level),
    .pulse    (pulse),
    .evt_flag (evt_flag),
    .any_evt  (any_evt)
`ifdef EDGE_CNT_EN
    ,
    .evt_cnt  (evt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [CH-1:0] mask;
  } exp_t;

  exp_t          sbq[$];
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  bit            mon_en = 1'b0;
  logic [CH-1:0] pexp;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every cycle pulse must equal the scheduled mask, or zero if none is due.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      pexp = '0;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        miscompares++;
        $error("FAIL pulse_overdue: scheduled cyc %0d mask %h never seen", sbq[0].cyc, sbq[0].mask);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        pexp = sbq[0].mask;
        void'(sbq.pop_front());
      end
      vectors++;
      assert (pulse === pexp) else begin
        miscompares++;
        $error("FAIL pulse cyc=%0d: got %h expected %h", cyc, pulse, pexp);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one channel at a negedge; if a pulse is expected, schedule it at capture edge +2+filt.
  task automatic drive(input int ch, input logic val, input bit exp_pulse, input int filt);
    exp_t e;
    sig_in[ch] = val;
    if (exp_pulse) begin
      e.cyc  = cyc + 3 + filt;
      e.mask = '0;
      e.mask[ch] = 1'b1;
      sbq.push_back(e);
    end
  endtask

  task automatic pulse_clr(input logic [CH-1:0] m);
    evt_clr = m;
    tick(1);
    evt_clr = '0;
  endtask

  initial begin
    exp_t e;
    rst_n    = 1'b0;
    sig_in   = 8'h08;
    mode     = '0;
    filt_len = 4'd0;
    evt_clr  = '0;
    tick(3);

    // Reset state
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_pulse", 32'(pulse), 32'h0);
    chk("rst_flag", 32'(evt_flag), 32'h0);
    chk("rst_any", 32'(any_evt), 32'h0);

    // Channel 3 held high through reset release: rising event two edges after first capture
    rst_n = 1'b1;
    e.cyc = cyc + 3; e.mask = 8'h08; sbq.push_back(e);
    mon_en = 1'b1;
    tick(2);
    chk("rel_level_early", 32'(level), 32'h0);
    tick(3);
    chk("rel_level", 32'(level), 32'h08);
    chk("rel_flag", 32'(evt_flag), 32'h08);
    chk("rel_any", 32'(any_evt), 32'h1);
    pulse_clr(8'h08);
    chk("rel_clr_flag", 32'(evt_flag), 32'h0);
    chk("rel_clr_any", 32'(any_evt), 32'h0);

    // Basic rise on ch0, filt_len=0
    drive(0, 1'b1, 1'b1, 0);
    tick(2);
    chk("t1_level_pre", 32'(level[0]), 32'h0);
    tick(1);
    chk("t1_level", 32'(level[0]), 32'h1);
    chk("t1_flag_pre", 32'(evt_flag[0]), 32'h0);
    tick(1);
    chk("t1_flag", 32'(evt_flag[0]), 32'h1);
    chk("t1_any", 32'(any_evt), 32'h1);
    pulse_clr(8'h01);

    // Glitch filter on ch1, filt_len=3, mode both
    filt_len = 4'd3;
    mode[3:2] = 2'b10;
    drive(1, 1'b1, 1'b0, 3);
    tick(3);
    drive(1, 1'b0, 1'b0, 3);
    tick(8);
    chk("t2_glitch_level", 32'(level[1]), 32'h0);
    drive(1, 1'b1, 1'b1, 3);
    tick(5);
    chk("t2_rise_level_pre", 32'(level[1]), 32'h0);
    tick(1);
    chk("t2_rise_level", 32'(level[1]), 32'h1);
    tick(2);
    drive(1, 1'b0, 1'b1, 3);
    tick(8);
    chk("t2_fall_level", 32'(level[1]), 32'h0);
    filt_len = 4'd0;

    // Fall mode on ch2, then mode off
    mode[5:4] = 2'b01;
    drive(2, 1'b1, 1'b0, 0);
    tick(4);
    chk("t3_level_hi", 32'(level[2]), 32'h1);
    drive(2, 1'b0, 1'b1, 0);
    tick(4);
    chk("t3_level_lo", 32'(level[2]), 32'h0);
    chk("t3_flag", 32'(evt_flag[2]), 32'h1);
    mode[5:4] = 2'b11;
    drive(2, 1'b1, 1'b0, 0);
    tick(4);
    chk("t3_off_level_hi", 32'(level[2]), 32'h1);
    drive(2, 1'b0, 1'b0, 0);
    tick(4);
    chk("t3_off_level_lo", 32'(level[2]), 32'h0);

    // Sticky clear on ch4: clear coinciding with the set loses
    pulse_clr('1);
    chk("t5_all_clear", 32'(evt_flag), 32'h0);
    drive(4, 1'b1, 1'b1, 0);
    tick(3);
    evt_clr = 8'h10;
    tick(1);
    evt_clr = '0;
    chk("t5_set_wins", 32'(evt_flag[4]), 32'h1);
    pulse_clr(8'h10);
    chk("t5_cleared", 32'(evt_flag), 32'h0);
    chk("t5_any", 32'(any_evt), 32'h0);

    // Reset mid filter count on ch6 (filt_len=5, count reaches 3)
    filt_len = 4'd5;
    drive(6, 1'b1, 1'b0, 5);
    tick(5);
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("t4_rst_level", 32'(level), 32'h0);
    chk("t4_rst_pulse", 32'(pulse), 32'h0);
    chk("t4_rst_flag", 32'(evt_flag), 32'h0);
    chk("t4_rst_any", 32'(any_evt), 32'h0);
    tick(2);
    rst_n = 1'b1;
    e.cyc = cyc + 3 + 5; e.mask = 8'h59; sbq.push_back(e);
    mon_en = 1'b1;
    tick(7);
    chk("t4_restart_pre", 32'(level), 32'h0);
    tick(1);
    chk("t4_restart", 32'(level), 32'h59);
    filt_len = 4'd0;
    tick(2);
    pulse_clr('1);

`ifdef EDGE_CNT_EN
    // Saturating counter on ch5, CNT_W=2
    for (int k = 0; k < 5; k++) begin
      drive(5, 1'b1, 1'b1, 0);
      tick(4);
      chk($sformatf("t6_cnt_%0d", k), 32'(evt_cnt[5*CNT_W +: CNT_W]), (k < 3) ? k + 1 : 3);
      drive(5, 1'b0, 1'b0, 0);
      tick(4);
    end
    drive(5, 1'b1, 1'b1, 0);
    tick(3);
    evt_clr = 8'h20;
    tick(1);
    evt_clr = '0;
    chk("t6_clr_with_pulse", 32'(evt_cnt[5*CNT_W +: CNT_W]), 32'h1);
    pulse_clr(8'h20);
    chk("t6_clr", 32'(evt_cnt[5*CNT_W +: CNT_W]), 32'h0);
`endif

    tick(4);
    mon_en = 1'b0;
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
